// File: rtl/classify_arbiter_pkg.sv
// Shared types and default sizes for the classify_arbiter slice: engine state
// encoding and the packed result record published on each completed request.
package classify_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       odd;
        logic [1:0] rem_3;
        logic       div_3;
        logic [1:0] rem_4;
        logic       div_4;
    } result_t;

endpackage

// File: rtl/classify_arbiter_mod3_engine.sv
// Iterative mod-3 engine: loads an operand on start, then subtracts 3 per clock
// until the accumulator drops below 3, at which point fin/rem/div are valid.
module mod3_engine
    import classify_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic [1:0]       rem,
    output logic             div,
    output logic             fin
);

    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // The >= 3 guard means the subtraction can never wrap
    always_comb begin
        acc_d = acc_q;
        if (start) begin
            acc_d = operand;
        end else if (acc_q >= THREE) begin
            acc_d = acc_q - THREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fin = (acc_q < THREE);
    assign rem = acc_q[1:0];
    assign div = (acc_q == '0);

endmodule

// File: rtl/classify_arbiter.sv
// Round-robin arbiter and sequencer sharing one mod3_engine among N_REQ
// requesters; returns parity, mod-3 and mod-4 classification per request.
module classify_arbiter
    import classify_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] num_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   odd,
    output logic [1:0]             rem_3,
    output logic                   div_3,
    output logic [1:0]             rem_4,
    output logic                   div_4
);

    localparam logic [ID_W-1:0] LAST_RESET = ID_W'(N_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    result_t         stage_q, stage_d;
    result_t         result_q, result_d;

    logic [ID_W-1:0]  winner;
    logic             found;
    logic             start;
    logic [WIDTH-1:0] win_operand;
    logic [1:0]       eng_rem;
    logic             eng_div;
    logic             eng_fin;

    // Search starts one past the previous winner so every requester gets a turn
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(last_q) + k) % N_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    assign win_operand = num_flat[int'(winner) * WIDTH +: WIDTH];
    assign start       = (state_q == IDLE) && found;

    always_comb begin
        gnt = '0;
        if (rst_n && start) begin
            gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        stage_d   = stage_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    last_d        = winner;
                    id_d          = winner;
                    stage_d       = '0;
                    stage_d.odd   = win_operand[0];
                    stage_d.rem_4 = win_operand[1:0];
                    stage_d.div_4 = (win_operand[1:0] == 2'b00);
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (eng_fin) begin
                    result_d       = stage_q;
                    result_d.rem_3 = eng_rem;
                    result_d.div_3 = eng_div;
                    done_id_d      = id_q;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_RESET;
            id_q      <= '0;
            done_id_q <= '0;
            stage_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            stage_q   <= stage_d;
            result_q  <= result_d;
        end
    end

    mod3_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .operand (win_operand),
        .rem     (eng_rem),
        .div     (eng_div),
        .fin     (eng_fin)
    );

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign odd     = result_q.odd;
    assign rem_3   = result_q.rem_3;
    assign div_3   = result_q.div_3;
    assign rem_4   = result_q.rem_4;
    assign div_4   = result_q.div_4;

endmodule

// File: tb/tb_classify_arbiter.sv
// Bench for classify_arbiter: a transaction-level countdown model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_classify_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] num_flat = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic                   odd;
    logic [1:0]             rem_3;
    logic                   div_3;
    logic [1:0]             rem_4;
    logic                   div_4;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    classify_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .num_flat (num_flat),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .odd      (odd),
        .rem_3    (rem_3),
        .div_3    (div_3),
        .rem_4    (rem_4),
        .div_4    (div_4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: a grant starts a countdown of n/3+1 edges, then one done cycle
    int m_last = N_REQ - 1;
    int m_wait = 0;
    bit m_done = 1'b0;
    int m_id = 0;
    int m_n = 0;
    int m_done_id = 0;
    int m_odd = 0;
    int m_rem3 = 0;
    int m_div3 = 0;
    int m_rem4 = 0;
    int m_div4 = 0;
    int m_pick;
    int m_opnd;
    logic [N_REQ-1:0] exp_gnt;

    function automatic int rrPick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int opOf(input logic [N_REQ*WIDTH-1:0] flat, input int i);
        if (i < 0) return 0;
        return int'(flat[i*WIDTH +: WIDTH]);
    endfunction

    always_comb m_pick = rrPick(req, m_last);
    always_comb m_opnd = opOf(num_flat, m_pick);

    always_comb begin
        exp_gnt = '0;
        if (rst_n && m_wait == 0 && !m_done && m_pick >= 0) exp_gnt[m_pick] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last    <= N_REQ - 1;
            m_wait    <= 0;
            m_done    <= 1'b0;
            m_done_id <= 0;
            m_odd     <= 0;
            m_rem3    <= 0;
            m_div3    <= 0;
            m_rem4    <= 0;
            m_div4    <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_done    <= 1'b1;
                m_done_id <= m_id;
                m_odd     <= m_n % 2;
                m_rem3    <= m_n % 3;
                m_div3    <= int'(m_n % 3 == 0);
                m_rem4    <= m_n % 4;
                m_div4    <= int'(m_n % 4 == 0);
            end
        end else if (m_pick >= 0) begin
            m_id   <= m_pick;
            m_last <= m_pick;
            m_n    <= m_opnd;
            m_wait <= m_opnd / 3 + 1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle away from the clock edge
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_gnt", int'(gnt), int'(exp_gnt));
            checkOutput("model_busy", int'(busy), int'(m_wait > 0 || m_done));
            checkOutput("model_done", int'(done), int'(m_done));
            checkOutput("model_done_id", int'(done_id), m_done_id);
            checkOutput("model_odd", int'(odd), m_odd);
            checkOutput("model_rem_3", int'(rem_3), m_rem3);
            checkOutput("model_div_3", int'(div_3), m_div3);
            checkOutput("model_rem_4", int'(rem_4), m_rem4);
            checkOutput("model_div_4", int'(div_4), m_div4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r);
        req = r;
    endtask

    task automatic setOperand(input int i, input int v);
        num_flat[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic doReset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic waitGnt(input int bound, output int idx, output int waited);
        idx = -1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
                break;
            end
            if (waited >= bound) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL wait_gnt: got no grant after %0d cycles, expected one", waited);
                break;
            end
            @(posedge clk);
            #1;
            waited++;
        end
    endtask

    task automatic waitDone(input int bound, output int edges);
        edges = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (edges >= bound) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL wait_done: got no done after %0d edges, expected one", edges);
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic checkResult(input string tag, input int id, input int o, input int r3,
                               input int d3, input int r4, input int d4);
        checkOutput({tag, "_done_id"}, int'(done_id), id);
        checkOutput({tag, "_odd"}, int'(odd), o);
        checkOutput({tag, "_rem_3"}, int'(rem_3), r3);
        checkOutput({tag, "_div_3"}, int'(div_3), d3);
        checkOutput({tag, "_rem_4"}, int'(rem_4), r4);
        checkOutput({tag, "_div_4"}, int'(div_4), d4);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int idx;
        int w;
        int edges;

        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_en = 1'b1;

        @(negedge clk);
        checkOutput("reset_gnt", int'(gnt), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkResult("reset", 0, 0, 0, 0, 0, 0);

        $display("[TB] single request, operand 9 on requester 2");
        step();
        setOperand(2, 9);
        applyStimulus(4'b0100);
        waitGnt(4, idx, w);
        checkOutput("t1_gnt", int'(gnt), 4);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkOutput("t1_latency", edges, 4);
        checkResult("t1", 2, 1, 0, 1, 1, 0);

        $display("[TB] all four requesting, operands 0..3");
        doReset();
        setOperand(0, 0);
        setOperand(1, 1);
        setOperand(2, 2);
        setOperand(3, 3);
        applyStimulus(4'b1111);
        for (int g = 0; g < 5; g++) begin
            waitGnt(4, idx, w);
            checkOutput("t2_order", idx, exp_order[g]);
            step();
            if (g == 4) applyStimulus(4'b0000);
            waitDone(100, edges);
            if (g == 0 || g == 4) begin
                checkOutput("t2_id0_div_3", int'(div_3), 1);
                checkOutput("t2_id0_div_4", int'(div_4), 1);
            end
            if (g == 3) begin
                checkOutput("t2_id3_rem_3", int'(rem_3), 0);
                checkOutput("t2_id3_rem_4", int'(rem_4), 3);
                checkOutput("t2_id3_odd", int'(odd), 1);
            end
        end

        $display("[TB] maximum operand 255");
        step();
        setOperand(3, 255);
        applyStimulus(4'b1000);
        waitGnt(4, idx, w);
        checkOutput("t3_gnt", int'(gnt), 8);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkOutput("t3_latency", edges, 86);
        checkResult("t3", 3, 1, 0, 1, 3, 0);

        $display("[TB] request arriving while busy");
        step();
        setOperand(0, 30);
        applyStimulus(4'b0001);
        waitGnt(4, idx, w);
        checkOutput("t4_gnt0", int'(gnt), 1);
        step();
        applyStimulus(4'b0000);
        step();
        setOperand(1, 7);
        applyStimulus(4'b0010);
        @(negedge clk);
        checkOutput("t4_gnt_while_busy", int'(gnt), 0);
        @(posedge clk);
        #1;
        waitDone(100, edges);
        checkOutput("t4_latency", edges, 9);
        waitGnt(4, idx, w);
        checkOutput("t4_gnt_wait", w, 0);
        checkOutput("t4_gnt1", int'(gnt), 2);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkResult("t4", 1, 1, 1, 0, 3, 0);

        $display("[TB] reset during a long run");
        step();
        setOperand(0, 200);
        applyStimulus(4'b0001);
        waitGnt(4, idx, w);
        step();
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_gnt", int'(gnt), 0);
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_done", int'(done), 0);
        checkResult("t5_rst", 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        waitGnt(2, idx, w);
        checkOutput("t5_regrant_wait", w, 0);
        checkOutput("t5_regrant", int'(gnt), 1);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkOutput("t5_latency", edges, 67);
        checkResult("t5", 0, 0, 2, 0, 0, 1);

        $display("[TB] operand 8 then 10 from one requester");
        step();
        setOperand(2, 8);
        applyStimulus(4'b0100);
        waitGnt(4, idx, w);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkResult("t6_first", 2, 0, 2, 0, 0, 1);
        repeat (3) step();
        @(negedge clk);
        checkOutput("t6_hold_rem_3", int'(rem_3), 2);
        checkOutput("t6_hold_div_4", int'(div_4), 1);
        step();
        setOperand(2, 10);
        applyStimulus(4'b0100);
        waitGnt(4, idx, w);
        checkOutput("t6_gnt", int'(gnt), 4);
        checkOutput("t6_hold_at_gnt_rem_3", int'(rem_3), 2);
        step();
        applyStimulus(4'b0000);
        waitDone(100, edges);
        checkResult("t6_second", 2, 0, 1, 0, 2, 0);

        step();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
